tt_um_b2nch_dreimann: RTL and testbench
=======================================

TT_UM_B2NCH_DREIMANN -- requirements
Module: tt_um_b2nch_dreimann

Interface
REQ-001 Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-high (rst_n=1 resets); port name kept from the TinyTapeout harness.
- ena  in  1  ignored.
- ui_in  in  8  [0] roll button; [2:1] player-count code; [3] unused; [6:4] test die A; [7] test mode.
- uio_in  in  8  [2:0] test die B; [7:3] unused.
- uo_out  out  8  [1:0] current player; [3:2] Drei-Mann player; [4] Drei-Mann drinks; [5] left neighbour drinks; [6] right neighbour drinks; [7] doubles.
- uio_out  out  8  [2:0] die A; [5:3] die B; [6] roll_done; [7] turn_passed.
- uio_oe  out  8  constant 8'hFF.
REQ-002 The block SHALL have no parameters.

Function
REQ-003 Player count N SHALL be ui_in[2:1]+1, with code 0 treated as N=2 (N in {2,3,4}), sampled at every roll.
REQ-004 Free-running die counters: cA SHALL step 1..6 every clock (6 wraps to 1); cB SHALL step 1..6 only on cycles where cA wraps.
REQ-005 A roll SHALL occur on a clock edge where ui_in[0]=1 and the registered previous ui_in[0] is 0; holding the button high SHALL produce exactly one roll.
REQ-006 Roll dice values:
- ui_in[7]=0: A=cA, B=cB at that edge.
- ui_in[7]=1: A=ui_in[6:4], B=uio_in[2:0], each clamped (0 becomes 1, 7 becomes 6).
REQ-007 On the roll edge, die registers and all flags SHALL update together, so outputs are valid in the following cycle (latency 1 clock). Flags SHALL hold until the next roll.
REQ-008 Rules, with S=A+B and cur=current player:
- Drei-Mann drinks = (A==3 or B==3).
- doubles = (A==B).
- left = (S==7).
- right = (S==11).
- If S==3, the Drei-Mann register SHALL load cur.
REQ-009 Turn rule: if none of {A==3, B==3, S==3, S==7, S==11, doubles} holds, cur SHALL become (cur+1>=N ? 0 : cur+1) and turn_passed=1. Otherwise cur SHALL be unchanged and turn_passed=0.
REQ-010 Neighbour identity (for documentation and LED decode): left=(cur+1>=N ? 0 : cur+1); right=(cur==0 ? N-1 : cur-1).
REQ-011 roll_done SHALL be a 1-cycle pulse in the cycle after each roll edge.
REQ-012 N changing between rolls SHALL only affect the next wrap computation; no other state is altered.

Reset
REQ-013 While rst_n=1 at a clock edge:
- cA=1, cB=1, A=1, B=1.
- cur=0, Drei-Mann=0.
- all flags 0, roll_done=0, previous-button register 0.
- Resulting outputs: uo_out=8'h00, uio_out=8'h09.
REQ-014 Reset mid-operation SHALL take priority over a simultaneous roll edge.

Verification
REQ-015 Reset -> uo_out=8'h00, uio_out=8'h09, uio_oe=8'hFF.
REQ-016 N=3, test mode, A=3, B=4, roll -> uo_out=8'h30; uio_out=8'h63 for one cycle, then 8'h23; cur stays 0.
REQ-017 From reset, N=3:
- A=2, B=4 roll -> cur=1, uio_out[7]=1.
- Then A=1, B=2 roll -> uo_out=8'h05 (cur=1, Drei-Mann=1).
REQ-018 cur=1, A=6, B=5 -> uo_out[6]=1, cur unchanged. Then A=4, B=4 -> uo_out[7]=1, cur unchanged.
REQ-019 N=2, cur=1, A=2, B=4 -> cur wraps to 0.
REQ-020 Button held high 5 cycles -> exactly one roll_done pulse. Release and re-press -> second pulse.

Source files
------------

// File: rtl/tt_um_b2nch_dreimann.sv
// "Drei-Mann" dice drinking-game controller: two free-running dice, roll on a
// button press, and game rules that decide who drinks and whose turn comes next.
module tt_um_b2nch_dreimann (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    logic [2:0] cnt_a, cnt_b;
    logic [2:0] die_a, die_b;
    logic [1:0] cur, dm_player;
    logic       btn_prev;
    logic       dm_drinks, left_drinks, right_drinks, doubles;
    logic       roll_done, turn_passed;

    logic       roll;
    logic [2:0] num_players;
    logic [2:0] roll_a, roll_b;
    logic [3:0] sum;
    logic [2:0] cur_inc;
    logic       wrap;
    logic       stay;
    logic       unused;

    assign unused = &{1'b0, ena, ui_in[3], uio_in[7:3]};

    function automatic logic [2:0] clamp_die(input logic [2:0] v);
        if (v == 3'd0)      return 3'd1;
        else if (v == 3'd7) return 3'd6;
        else                return v;
    endfunction

    always_comb begin
        roll        = ui_in[0] & ~btn_prev;
        num_players = (ui_in[2:1] == 2'd0) ? 3'd2 : {1'b0, ui_in[2:1]} + 3'd1;
        roll_a      = ui_in[7] ? clamp_die(ui_in[6:4]) : cnt_a;
        roll_b      = ui_in[7] ? clamp_die(uio_in[2:0]) : cnt_b;
        sum         = {1'b0, roll_a} + {1'b0, roll_b};
        cur_inc     = {1'b0, cur} + 3'd1;
        wrap        = (cur_inc >= num_players);
        // Any 3, a sum of 3/7/11 or a pair keeps the turn with the current player
        stay        = (roll_a == 3'd3) || (roll_b == 3'd3) || (sum == 4'd3) ||
                      (sum == 4'd7) || (sum == 4'd11) || (roll_a == roll_b);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt_a        <= 3'd1;
            cnt_b        <= 3'd1;
            die_a        <= 3'd1;
            die_b        <= 3'd1;
            cur          <= '0;
            dm_player    <= '0;
            btn_prev     <= 1'b0;
            dm_drinks    <= 1'b0;
            left_drinks  <= 1'b0;
            right_drinks <= 1'b0;
            doubles      <= 1'b0;
            roll_done    <= 1'b0;
            turn_passed  <= 1'b0;
        end else begin
            if (cnt_a == 3'd6) begin
                cnt_a <= 3'd1;
                cnt_b <= (cnt_b == 3'd6) ? 3'd1 : cnt_b + 3'd1;
            end else begin
                cnt_a <= cnt_a + 3'd1;
            end
            btn_prev  <= ui_in[0];
            roll_done <= roll;
            if (roll) begin
                die_a        <= roll_a;
                die_b        <= roll_b;
                dm_drinks    <= (roll_a == 3'd3) || (roll_b == 3'd3);
                doubles      <= (roll_a == roll_b);
                left_drinks  <= (sum == 4'd7);
                right_drinks <= (sum == 4'd11);
                turn_passed  <= ~stay;
                if (sum == 4'd3)
                    dm_player <= cur;
                if (!stay)
                    cur <= wrap ? 2'd0 : cur + 2'd1;
            end
        end
    end

    assign uo_out  = {doubles, right_drinks, left_drinks, dm_drinks, dm_player, cur};
    assign uio_out = {turn_passed, roll_done, die_b, die_a};
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_b2nch_dreimann.sv
// Directed bench for tt_um_b2nch_dreimann: a behavioural game model pushes the
// expected outputs for every roll to a queue, popped when the DUT responds.
module tb_tt_um_b2nch_dreimann;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in, uio_in;
    logic [7:0] uo_out, uio_out, uio_oe;

    typedef struct {
        logic [7:0] uo;
        logic [7:0] uio;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    logic [2:0] m_ca, m_cb;
    logic [1:0] m_cur, m_dm;

    tt_um_b2nch_dreimann dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    always #5 clk = ~clk;

    // Reference model of the free-running dice
    always @(posedge clk) begin
        if (rst_n) begin
            m_ca <= 3'd1;
            m_cb <= 3'd1;
        end else if (m_ca == 3'd6) begin
            m_ca <= 3'd1;
            m_cb <= (m_cb == 3'd6) ? 3'd1 : m_cb + 3'd1;
        end else begin
            m_ca <= m_ca + 3'd1;
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    function automatic logic [2:0] clampv(input logic [2:0] v);
        if (v == 3'd0) return 3'd1;
        if (v == 3'd7) return 3'd6;
        return v;
    endfunction

    // Called at a negedge with the button low; leaves the button low again.
    task automatic do_roll(input string tag, input logic tm, input logic [2:0] a,
                           input logic [2:0] b, input int n);
        logic [2:0] da, db;
        logic [3:0] s;
        logic       stay;
        logic [1:0] code;
        exp_t       e, got;
        code   = (n == 2) ? 2'd1 : 2'(n - 1);
        ui_in  = {tm, a, 1'b0, code, 1'b1};
        uio_in = {5'd0, b};
        da = tm ? clampv(a) : m_ca;
        db = tm ? clampv(b) : m_cb;
        s  = {1'b0, da} + {1'b0, db};
        stay = (da == 3) || (db == 3) || (s == 3) || (s == 7) || (s == 11) || (da == db);
        if (s == 3) m_dm = m_cur;
        if (!stay) m_cur = (int'(m_cur) + 1 >= n) ? 2'd0 : m_cur + 2'd1;
        e.uo  = {da == db, s == 11, s == 7, (da == 3) || (db == 3), m_dm, m_cur};
        e.uio = {!stay, 1'b1, db, da};
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        check({tag, " uo"}, uo_out, got.uo);
        check({tag, " uio"}, uio_out, got.uio);
        ui_in[0] = 1'b0;
        @(negedge clk);
        check({tag, " uio_hold"}, uio_out, got.uio & 8'hBF);
        check({tag, " uo_hold"}, uo_out, got.uo);
    endtask

    initial begin
        int pulses;
        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = '0;
        uio_in = '0;
        m_cur  = '0;
        m_dm   = '0;
        repeat (3) @(negedge clk);
        check("reset uo", uo_out, 8'h00);
        check("reset uio", uio_out, 8'h09);
        check("reset oe", uio_oe, 8'hFF);
        rst_n = 1'b0;
        @(negedge clk);

        do_roll("n3_a3b4", 1'b1, 3'd3, 3'd4, 3);
        check("n3_a3b4 value", uo_out, 8'h30);
        do_roll("n3_a2b4", 1'b1, 3'd2, 3'd4, 3);
        check("n3_a2b4 pass", uio_out, 8'hA2);
        do_roll("n3_a1b2", 1'b1, 3'd1, 3'd2, 3);
        check("n3_a1b2 value", uo_out, 8'h05);
        do_roll("a6b5", 1'b1, 3'd6, 3'd5, 3);
        check("a6b5 value", uo_out, 8'h45);
        do_roll("a4b4", 1'b1, 3'd4, 3'd4, 3);
        check("a4b4 value", uo_out, 8'h85);
        do_roll("n2_wrap", 1'b1, 3'd2, 3'd4, 2);
        check("n2_wrap value", uo_out, 8'h04);
        do_roll("clamp", 1'b1, 3'd0, 3'd7, 4);
        check("clamp dice", uio_out & 8'h3F, 8'h31);
        do_roll("free1", 1'b0, 3'd0, 3'd0, 4);
        repeat (3) @(negedge clk);
        do_roll("free2", 1'b0, 3'd0, 3'd0, 3);

        // Held button: only the rising edge counts
        pulses = 0;
        ui_in  = {1'b1, 3'd5, 1'b0, 2'd2, 1'b1};
        uio_in = 8'd6;
        repeat (5) begin
            @(negedge clk);
            if (uio_out[6]) pulses++;
        end
        check("hold pulses", 8'(pulses), 8'd1);
        ui_in[0] = 1'b0;
        repeat (2) @(negedge clk);
        pulses = 0;
        ui_in[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (uio_out[6]) pulses++;
        end
        check("repress pulses", 8'(pulses), 8'd1);
        ui_in[0] = 1'b0;
        @(negedge clk);

        // Reset wins over a simultaneous roll edge
        rst_n    = 1'b1;
        ui_in    = {1'b1, 3'd2, 1'b0, 2'd2, 1'b1};
        uio_in   = 8'd4;
        @(negedge clk);
        check("rst_prio uo", uo_out, 8'h00);
        check("rst_prio uio", uio_out, 8'h09);
        ui_in[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("post_rst uio", uio_out, 8'h09);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
